// File: rtl/flash_stream_reader.sv
// flash_stream_reader
// Reads a burst of NUM_WORDS 32-bit words from SPI flash through the
// spi_master address/read handshake and replays them as a byte stream,
// most significant byte first, with a valid/ready handshake.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   start                   one-cycle burst request (sampled only in IDLE)
//   spi_addr_buffer_free    spi_master can take an address
//   spi_addr_en             one-cycle address strobe to spi_master
//   spi_addr_data           flash byte address
//   spi_rd_data_available   spi_master holds a valid word
//   spi_rd_ack              one-cycle release of the spi_master word
//   spi_rd_data             word from flash, [31:24] is the lowest address byte
//   out_valid/out_ready     byte stream handshake
//   out_data                stream byte
//   out_last                marks the final byte of the burst
//   busy                    burst in progress
//   done                    one-cycle pulse after the final byte is accepted
module flash_stream_reader #(
   parameter logic [23:0] START_ADDR     = 24'h100000,
   parameter int          NUM_WORDS      = 4,
   parameter logic [31:0] STARTUP_CYCLES = 32'h1000000,
   parameter bit          AUTO_START     = 1'b1,
   parameter bit          LOOP           = 1'b0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        spi_addr_buffer_free,
   output logic        spi_addr_en,
   output logic [23:0] spi_addr_data,
   input  logic        spi_rd_data_available,
   output logic        spi_rd_ack,
   input  logic [31:0] spi_rd_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_data,
   output logic        out_last,
   output logic        busy,
   output logic        done
);

   localparam int             WCW       = $clog2(NUM_WORDS + 1);
   localparam logic [WCW-1:0] LAST_WORD = WCW'(NUM_WORDS);

   localparam logic [2:0] ST_STARTUP = 3'd0;
   localparam logic [2:0] ST_IDLE    = 3'd1;
   localparam logic [2:0] ST_ISSUE   = 3'd2;
   localparam logic [2:0] ST_WAIT    = 3'd3;
   localparam logic [2:0] ST_FLUSH   = 3'd4;

   logic [2:0]     state;
   logic [31:0]    startup_cnt;
   logic [23:0]    addr;
   logic [WCW-1:0] words_issued;
   logic [31:0]    buf_word;
   logic           buf_full;
   logic           buf_last;
   logic [1:0]     byte_idx;
   logic           done_q;

   logic issue_fire;
   logic capture_fire;
   logic byte_fire;
   logic last_fire;

   // Handshake events. The address strobe and the read ack are Mealy
   // outputs so each lasts exactly the cycle in which it is consumed.
   // A word is only taken once the previous one has fully drained, so
   // spi_master keeps holding it while bytes are still going out.
   assign issue_fire   = (state == ST_ISSUE) && spi_addr_buffer_free;
   assign capture_fire = (state == ST_WAIT) && spi_rd_data_available && !buf_full;
   assign byte_fire    = buf_full && out_ready;
   assign last_fire    = byte_fire && buf_last && (byte_idx == 2'd3);

   assign spi_addr_en   = issue_fire;
   assign spi_addr_data = addr;
   assign spi_rd_ack    = capture_fire;
   assign out_valid     = buf_full;
   assign out_data      = buf_word[31:24];
   assign out_last      = buf_full && buf_last && (byte_idx == 2'd3);
   assign done          = done_q;
   // The done cycle reads as not busy even when looping straight back
   // into ISSUE, so a consumer sees a clean burst boundary.
   assign busy          = ((state == ST_ISSUE) || (state == ST_WAIT) ||
                           (state == ST_FLUSH)) && !done_q;

   // Burst sequencing: settle delay, address issue with one word of
   // prefetch, then wait for the final byte before finishing or looping.
   // start is ignored during the done cycle so a request racing the end
   // of a burst cannot immediately retrigger it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_STARTUP;
         startup_cnt  <= 32'd0;
         addr         <= START_ADDR;
         words_issued <= '0;
         done_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            ST_STARTUP: begin
               startup_cnt <= startup_cnt + 32'd1;
               if ((startup_cnt + 32'd1) >= STARTUP_CYCLES) begin
                  state <= AUTO_START ? ST_ISSUE : ST_IDLE;
               end
            end
            ST_IDLE: begin
               if (start && !done_q) begin
                  state <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (issue_fire) begin
                  addr         <= addr + 24'd4;
                  words_issued <= words_issued + 1'b1;
                  state        <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (capture_fire) begin
                  state <= (words_issued < LAST_WORD) ? ST_ISSUE : ST_FLUSH;
               end
            end
            ST_FLUSH: begin
               if (last_fire) begin
                  done_q       <= 1'b1;
                  addr         <= START_ADDR;
                  words_issued <= '0;
                  state        <= LOOP ? ST_ISSUE : ST_IDLE;
               end
            end
            default: state <= ST_STARTUP;
         endcase
      end
   end

   // One-word byte buffer. Bytes leave from the top of a shift register,
   // so out_data stays put while the consumer stalls. The word captured
   // when words_issued has reached NUM_WORDS is the last of the burst.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         buf_word <= 32'd0;
         buf_full <= 1'b0;
         buf_last <= 1'b0;
         byte_idx <= 2'd0;
      end else if (capture_fire) begin
         buf_word <= spi_rd_data;
         buf_full <= 1'b1;
         buf_last <= (words_issued == LAST_WORD);
         byte_idx <= 2'd0;
      end else if (byte_fire) begin
         buf_word <= {buf_word[23:0], 8'h00};
         byte_idx <= byte_idx + 2'd1;
         if (byte_idx == 2'd3) begin
            buf_full <= 1'b0;
            buf_last <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_flash_stream_reader.sv
// tb_flash_stream_reader
// Four reader instances with a 16-cycle settle delay, each with its own
// small spi_master/flash model:
//   inst[0] nominal (START 0x100000, 2 words, auto start)
//   inst[1] manual start (AUTO_START=0)
//   inst[2] address wrap (START 0xFFFFFC)
//   inst[3] loop mode, 1 word
// The flash returns {a, a+1, a+2, a+3} where a is the low address byte.
module tb_flash_stream_reader;

   logic       clk = 1'b0;
   logic [3:0] rst_n_v;
   logic [3:0] start_v;
   logic [3:0] ready_v;
   int         cyc = 0;
   int         compared = 0;
   int         mismatched = 0;

   always #5 clk = ~clk;

   // Free-running edge counter used to time-stamp logged events.
   always @(posedge clk) cyc <= cyc + 1;

   genvar g;
   for (g = 0; g < 4; g++) begin : inst
      localparam logic [23:0] SA = (g == 2) ? 24'hFFFFFC : 24'h100000;
      localparam int          NW = (g == 3) ? 1 : 2;
      localparam bit          AS = (g == 1) ? 1'b0 : 1'b1;
      localparam bit          LP = (g == 3) ? 1'b1 : 1'b0;

      logic        addr_free;
      logic        addr_en;
      logic [23:0] addr_data;
      logic        rd_avail;
      logic        rd_ack;
      logic [31:0] rd_data;
      logic        out_valid;
      logic [7:0]  out_data;
      logic        out_last;
      logic        busy;
      logic        done;

      logic [23:0] pend_addr;
      int          lat;

      logic [23:0] addr_log [16];
      int          addr_stamp [16];
      int          addr_cnt = 0;
      int          ack_stamp [16];
      int          ack_cnt = 0;
      logic [7:0]  byte_log [64];
      logic        last_log [64];
      int          byte_stamp [64];
      int          byte_cnt = 0;
      int          done_cnt = 0;

      flash_stream_reader #(
         .START_ADDR(SA), .NUM_WORDS(NW), .STARTUP_CYCLES(32'd16),
         .AUTO_START(AS), .LOOP(LP)
      ) dut (
         .clk(clk), .reset_n(rst_n_v[g]), .start(start_v[g]),
         .spi_addr_buffer_free(addr_free), .spi_addr_en(addr_en),
         .spi_addr_data(addr_data), .spi_rd_data_available(rd_avail),
         .spi_rd_ack(rd_ack), .spi_rd_data(rd_data),
         .out_valid(out_valid), .out_ready(ready_v[g]), .out_data(out_data),
         .out_last(out_last), .busy(busy), .done(done)
      );

      // spi_master stand-in: one outstanding read, word ready three
      // cycles after the address, held until acknowledged.
      always @(posedge clk or negedge rst_n_v[g]) begin
         if (!rst_n_v[g]) begin
            addr_free <= 1'b1;
            rd_avail  <= 1'b0;
            rd_data   <= 32'd0;
            pend_addr <= 24'd0;
            lat       <= 0;
         end else begin
            if (addr_en) begin
               pend_addr <= addr_data;
               lat       <= 3;
               addr_free <= 1'b0;
            end else if (lat == 1) begin
               lat      <= 0;
               rd_avail <= 1'b1;
               rd_data  <= {pend_addr[7:0], pend_addr[7:0] + 8'd1,
                            pend_addr[7:0] + 8'd2, pend_addr[7:0] + 8'd3};
            end else if (lat > 1) begin
               lat <= lat - 1;
            end
            if (rd_ack) begin
               rd_avail  <= 1'b0;
               addr_free <= 1'b1;
            end
         end
      end

      // Event log sampled mid-cycle; stamps give the edge that consumes it.
      always @(negedge clk) begin
         if (rst_n_v[g]) begin
            if (addr_en) begin
               if (addr_cnt < 16) begin
                  addr_log[addr_cnt]   <= addr_data;
                  addr_stamp[addr_cnt] <= cyc + 1;
               end
               addr_cnt <= addr_cnt + 1;
            end
            if (rd_ack) begin
               if (ack_cnt < 16) ack_stamp[ack_cnt] <= cyc + 1;
               ack_cnt <= ack_cnt + 1;
            end
            if (out_valid && ready_v[g]) begin
               if (byte_cnt < 64) begin
                  byte_log[byte_cnt]   <= out_data;
                  last_log[byte_cnt]   <= out_last;
                  byte_stamp[byte_cnt] <= cyc + 1;
               end
               byte_cnt <= byte_cnt + 1;
            end
            if (done) done_cnt <= done_cnt + 1;
         end
      end
   end

   task automatic test_reset();
      rst_n_v = 4'b0000;
      start_v = 4'b0000;
      ready_v = 4'b0000;
      repeat (2) @(posedge clk);
      @(negedge clk);
      compared++; if (inst[0].addr_en !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_addr_en: got %0b, expected 0", inst[0].addr_en); end
      compared++; if (inst[0].rd_ack !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_rd_ack: got %0b, expected 0", inst[0].rd_ack); end
      compared++; if (inst[0].addr_data !== 24'h100000) begin mismatched++; $display("[TB] FAIL reset_addr_data: got %0h, expected 100000", inst[0].addr_data); end
      compared++; if (inst[2].addr_data !== 24'hFFFFFC) begin mismatched++; $display("[TB] FAIL reset_addr_data_wrap: got %0h, expected fffffc", inst[2].addr_data); end
      compared++; if (inst[0].out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_valid: got %0b, expected 0", inst[0].out_valid); end
      compared++; if (inst[0].out_data !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_out_data: got %0h, expected 00", inst[0].out_data); end
      compared++; if (inst[0].out_last !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_last: got %0b, expected 0", inst[0].out_last); end
      compared++; if (inst[0].busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %0b, expected 0", inst[0].busy); end
      compared++; if (inst[0].done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done: got %0b, expected 0", inst[0].done); end
   endtask

   task automatic test_nominal();
      int c0;
      ready_v[0] = 1'b1;
      @(posedge clk); #1;
      rst_n_v[0] = 1'b1;
      c0 = cyc;
      for (int i = 0; i < 300 && inst[0].done_cnt == 0; i++) @(negedge clk);
      compared++; if (inst[0].done_cnt == 0) begin mismatched++; $display("[TB] FAIL nominal_timeout: done count %0d, expected 1", inst[0].done_cnt); end
      repeat (20) @(negedge clk);
      compared++; if (inst[0].addr_cnt !== 2) begin mismatched++; $display("[TB] FAIL nominal_addr_count: got %0d, expected 2", inst[0].addr_cnt); end
      compared++; if (inst[0].addr_log[0] !== 24'h100000) begin mismatched++; $display("[TB] FAIL nominal_addr0: got %0h, expected 100000", inst[0].addr_log[0]); end
      compared++; if (inst[0].addr_log[1] !== 24'h100004) begin mismatched++; $display("[TB] FAIL nominal_addr1: got %0h, expected 100004", inst[0].addr_log[1]); end
      compared++; if (inst[0].addr_stamp[0] - c0 !== 17) begin mismatched++; $display("[TB] FAIL nominal_startup_delay: first strobe at edge %0d, expected 17", inst[0].addr_stamp[0] - c0); end
      compared++; if (inst[0].byte_cnt !== 8) begin mismatched++; $display("[TB] FAIL nominal_byte_count: got %0d, expected 8", inst[0].byte_cnt); end
      for (int k = 0; k < 8; k++) begin
         compared++;
         if (inst[0].byte_log[k] !== 8'(k) || inst[0].last_log[k] !== (k == 7)) begin
            mismatched++;
            $display("[TB] FAIL nominal_byte%0d: got %0h last %0b, expected %0h last %0b", k, inst[0].byte_log[k], inst[0].last_log[k], k, (k == 7));
         end
      end
      compared++; if (inst[0].done_cnt !== 1) begin mismatched++; $display("[TB] FAIL nominal_done_pulses: got %0d, expected 1", inst[0].done_cnt); end
      compared++; if (inst[0].busy !== 1'b0) begin mismatched++; $display("[TB] FAIL nominal_busy_after: got %0b, expected 0", inst[0].busy); end
   endtask

   task automatic test_backpressure();
      int bb;
      int kb;
      int db;
      rst_n_v[0] = 1'b0;
      ready_v[0] = 1'b0;
      @(posedge clk); #1;
      rst_n_v[0] = 1'b1;
      bb = inst[0].byte_cnt;
      kb = inst[0].ack_cnt;
      db = inst[0].done_cnt;
      for (int i = 0; i < 300 && !inst[0].out_valid; i++) @(negedge clk);
      compared++; if (inst[0].out_valid !== 1'b1 || inst[0].out_data !== 8'h00) begin mismatched++; $display("[TB] FAIL bp_first_byte: valid %0b data %0h, expected 1 00", inst[0].out_valid, inst[0].out_data); end
      @(posedge clk); #1;
      ready_v[0] = 1'b1;
      @(posedge clk); #1;
      ready_v[0] = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         compared++;
         if (inst[0].out_valid !== 1'b1 || inst[0].out_data !== 8'h01 || inst[0].rd_ack !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL bp_hold%0d: valid %0b data %0h ack %0b, expected 1 01 0", i, inst[0].out_valid, inst[0].out_data, inst[0].rd_ack);
         end
      end
      compared++; if (inst[0].ack_cnt - kb !== 1) begin mismatched++; $display("[TB] FAIL bp_acks_during_hold: got %0d, expected 1", inst[0].ack_cnt - kb); end
      @(posedge clk); #1;
      ready_v[0] = 1'b1;
      for (int i = 0; i < 300 && inst[0].done_cnt == db; i++) @(negedge clk);
      compared++; if (inst[0].done_cnt == db) begin mismatched++; $display("[TB] FAIL bp_timeout: done count %0d, expected %0d", inst[0].done_cnt, db + 1); end
      repeat (5) @(negedge clk);
      compared++; if (inst[0].byte_cnt - bb !== 8) begin mismatched++; $display("[TB] FAIL bp_byte_count: got %0d, expected 8", inst[0].byte_cnt - bb); end
      for (int k = 0; k < 8; k++) begin
         compared++;
         if (inst[0].byte_log[bb + k] !== 8'(k) || inst[0].last_log[bb + k] !== (k == 7)) begin
            mismatched++;
            $display("[TB] FAIL bp_byte%0d: got %0h last %0b, expected %0h last %0b", k, inst[0].byte_log[bb + k], inst[0].last_log[bb + k], k, (k == 7));
         end
      end
      compared++; if (inst[0].ack_stamp[kb + 1] <= inst[0].byte_stamp[bb + 3]) begin mismatched++; $display("[TB] FAIL bp_second_ack_order: ack edge %0d, expected after byte3 edge %0d", inst[0].ack_stamp[kb + 1], inst[0].byte_stamp[bb + 3]); end
   endtask

   task automatic test_reset_mid_burst();
      int c0;
      int bb;
      int ab;
      int db;
      rst_n_v[0] = 1'b0;
      ready_v[0] = 1'b1;
      @(posedge clk); #1;
      rst_n_v[0] = 1'b1;
      bb = inst[0].byte_cnt;
      for (int i = 0; i < 300 && inst[0].byte_cnt < bb + 3; i++) @(negedge clk);
      compared++; if (inst[0].busy !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_busy_before: got %0b, expected 1", inst[0].busy); end
      #1;
      rst_n_v[0] = 1'b0;
      #1;
      compared++; if (inst[0].out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_out_valid: got %0b, expected 0", inst[0].out_valid); end
      compared++; if (inst[0].addr_en !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_addr_en: got %0b, expected 0", inst[0].addr_en); end
      compared++; if (inst[0].busy !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_busy: got %0b, expected 0", inst[0].busy); end
      repeat (2) @(posedge clk);
      #1;
      rst_n_v[0] = 1'b1;
      c0 = cyc;
      bb = inst[0].byte_cnt;
      ab = inst[0].addr_cnt;
      db = inst[0].done_cnt;
      for (int i = 0; i < 300 && inst[0].done_cnt == db; i++) @(negedge clk);
      compared++; if (inst[0].done_cnt == db) begin mismatched++; $display("[TB] FAIL mid_timeout: done count %0d, expected %0d", inst[0].done_cnt, db + 1); end
      repeat (3) @(negedge clk);
      compared++; if (inst[0].addr_log[ab] !== 24'h100000) begin mismatched++; $display("[TB] FAIL mid_restart_addr: got %0h, expected 100000", inst[0].addr_log[ab]); end
      compared++; if (inst[0].addr_stamp[ab] - c0 !== 17) begin mismatched++; $display("[TB] FAIL mid_restart_delay: first strobe at edge %0d, expected 17", inst[0].addr_stamp[ab] - c0); end
      compared++; if (inst[0].byte_cnt - bb !== 8 || inst[0].byte_log[bb] !== 8'h00 || inst[0].byte_log[bb + 7] !== 8'h07) begin
         mismatched++;
         $display("[TB] FAIL mid_restart_stream: count %0d first %0h last %0h, expected 8 00 07", inst[0].byte_cnt - bb, inst[0].byte_log[bb], inst[0].byte_log[bb + 7]);
      end
   endtask

   task automatic test_startup_start();
      int c0;
      ready_v[1] = 1'b1;
      @(posedge clk); #1;
      rst_n_v[1] = 1'b1;
      c0 = cyc;
      // start pulses sampled at edges 2 and 10 and then at 20
      for (int e = 1; e <= 19; e++) begin
         @(posedge clk); #1;
         start_v[1] = (e == 1 || e == 9 || e == 19);
      end
      @(negedge clk);
      compared++; if (inst[1].addr_cnt !== 0 || inst[1].busy !== 1'b0) begin mismatched++; $display("[TB] FAIL startup_ignored: strobes %0d busy %0b, expected 0 0", inst[1].addr_cnt, inst[1].busy); end
      @(posedge clk); #1;
      start_v[1] = 1'b0;
      repeat (3) @(negedge clk);
      compared++; if (inst[1].addr_cnt < 1 || inst[1].addr_stamp[0] - c0 < 21 || inst[1].addr_stamp[0] - c0 > 22) begin
         mismatched++;
         $display("[TB] FAIL startup_first_strobe: strobes %0d at edge %0d, expected edge 21..22", inst[1].addr_cnt, inst[1].addr_stamp[0] - c0);
      end
      compared++; if (inst[1].addr_log[0] !== 24'h100000) begin mismatched++; $display("[TB] FAIL startup_addr: got %0h, expected 100000", inst[1].addr_log[0]); end
      for (int i = 0; i < 300 && !inst[1].done; i++) @(negedge clk);
      compared++; if (inst[1].done !== 1'b1) begin mismatched++; $display("[TB] FAIL startup_done_timeout: done %0b, expected 1", inst[1].done); end
      // start coinciding with done must not start a new burst
      start_v[1] = 1'b1;
      @(posedge clk); #1;
      start_v[1] = 1'b0;
      repeat (30) @(negedge clk);
      compared++; if (inst[1].addr_cnt !== 2 || inst[1].busy !== 1'b0) begin mismatched++; $display("[TB] FAIL start_at_done: strobes %0d busy %0b, expected 2 0", inst[1].addr_cnt, inst[1].busy); end
      @(posedge clk); #1;
      start_v[1] = 1'b1;
      @(posedge clk); #1;
      start_v[1] = 1'b0;
      for (int i = 0; i < 300 && inst[1].done_cnt < 2; i++) @(negedge clk);
      compared++; if (inst[1].addr_cnt !== 4 || inst[1].addr_log[2] !== 24'h100000 || inst[1].addr_log[3] !== 24'h100004) begin
         mismatched++;
         $display("[TB] FAIL restart_from_idle: strobes %0d addr %0h %0h, expected 4 100000 100004", inst[1].addr_cnt, inst[1].addr_log[2], inst[1].addr_log[3]);
      end
   endtask

   task automatic test_wrap();
      logic [7:0] exp_w [8];
      exp_w = '{8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03};
      ready_v[2] = 1'b1;
      @(posedge clk); #1;
      rst_n_v[2] = 1'b1;
      for (int i = 0; i < 300 && inst[2].done_cnt == 0; i++) @(negedge clk);
      compared++; if (inst[2].done_cnt == 0) begin mismatched++; $display("[TB] FAIL wrap_timeout: done count %0d, expected 1", inst[2].done_cnt); end
      repeat (3) @(negedge clk);
      compared++; if (inst[2].addr_log[0] !== 24'hFFFFFC) begin mismatched++; $display("[TB] FAIL wrap_addr0: got %0h, expected fffffc", inst[2].addr_log[0]); end
      compared++; if (inst[2].addr_log[1] !== 24'h000000) begin mismatched++; $display("[TB] FAIL wrap_addr1: got %0h, expected 000000", inst[2].addr_log[1]); end
      for (int k = 0; k < 8; k++) begin
         compared++;
         if (inst[2].byte_log[k] !== exp_w[k] || inst[2].last_log[k] !== (k == 7)) begin
            mismatched++;
            $display("[TB] FAIL wrap_byte%0d: got %0h last %0b, expected %0h last %0b", k, inst[2].byte_log[k], inst[2].last_log[k], exp_w[k], (k == 7));
         end
      end
   endtask

   task automatic test_loop();
      ready_v[3] = 1'b1;
      @(posedge clk); #1;
      rst_n_v[3] = 1'b1;
      for (int i = 0; i < 300 && inst[3].done_cnt == 0; i++) @(negedge clk);
      for (int i = 0; i < 50 && inst[3].busy !== 1'b1; i++) @(negedge clk);
      @(posedge clk); #1;
      start_v[3] = 1'b1;
      @(posedge clk); #1;
      start_v[3] = 1'b0;
      for (int i = 0; i < 300 && inst[3].done_cnt < 3; i++) @(negedge clk);
      rst_n_v[3] = 1'b0;
      compared++; if (inst[3].done_cnt < 3) begin mismatched++; $display("[TB] FAIL loop_timeout: done count %0d, expected 3", inst[3].done_cnt); end
      compared++; if (inst[3].addr_cnt - inst[3].done_cnt < 0 || inst[3].addr_cnt - inst[3].done_cnt > 1) begin
         mismatched++;
         $display("[TB] FAIL loop_strobe_count: strobes %0d for %0d bursts, expected equal or one more", inst[3].addr_cnt, inst[3].done_cnt);
      end
      for (int k = 0; k < 3; k++) begin
         compared++;
         if (inst[3].addr_log[k] !== 24'h100000) begin mismatched++; $display("[TB] FAIL loop_addr%0d: got %0h, expected 100000", k, inst[3].addr_log[k]); end
      end
      for (int k = 0; k < 12; k++) begin
         compared++;
         if (inst[3].byte_log[k] !== 8'(k % 4) || inst[3].last_log[k] !== (k % 4 == 3)) begin
            mismatched++;
            $display("[TB] FAIL loop_byte%0d: got %0h last %0b, expected %0h last %0b", k, inst[3].byte_log[k], inst[3].last_log[k], k % 4, (k % 4 == 3));
         end
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_backpressure();
      test_reset_mid_burst();
      test_startup_start();
      test_wrap();
      test_loop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/flash_stream_reader.md
Name: flash_stream_reader

Overview:
- Parametrised successor to the single-word flash-read-to-LED control logic. Drives the existing spi_master command/read handshake.
- After a power-up settle delay, reads a burst of NUM_WORDS 32-bit words from flash, starting at START_ADDR.
- Presents the burst as a byte stream with valid/ready handshake and end-of-burst marker. Supports optional auto-start and continuous loop modes.
- Sits between spi_master and any consumer, e.g. LED logic, config loaders or sample players.

Parameters:
- START_ADDR, 24'h100000, flash byte address of the first word.
- NUM_WORDS, 4, words per burst; must be >= 1.
- STARTUP_CYCLES, 32'h1000000, settle cycles after reset before any SPI activity.
- AUTO_START, 1, when 1, a burst starts automatically when the startup delay expires.
- LOOP, 0, when 1, a new burst from START_ADDR begins immediately after done.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a burst
- spi_addr_buffer_free  in  1  spi_master can accept an address
- spi_addr_en  out  1  one-cycle address strobe to spi_master
- spi_addr_data  out  24  flash byte address
- spi_rd_data_available  in  1  spi_master holds a valid word
- spi_rd_ack  out  1  one-cycle acknowledge; releases the spi_master word
- spi_rd_data  in  32  word; [31:24] = lowest address byte
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts the byte
- out_data  out  8  stream byte
- out_last  out  1  qualifies the final byte of a burst
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse after the last byte is accepted

Behaviour:
- Reset, asynchronous, all outputs immediately:
  - spi_addr_en=0, spi_rd_ack=0, spi_addr_data=START_ADDR
  - out_valid=0, out_data=0, out_last=0, busy=0, done=0
  - FSM=STARTUP; startup counter=0; byte buffer empty.
- STARTUP:
  - Counter increments each cycle. When it reaches STARTUP_CYCLES, go to IDLE.
  - If AUTO_START=1, go to ISSUE instead of IDLE.
  - start is ignored while in STARTUP.
- IDLE: start=1 -> ISSUE. busy=0.
- ISSUE:
  - busy=1.
  - When spi_addr_buffer_free=1: drive spi_addr_en=1 for exactly one cycle with spi_addr_data=current address, then go to WAIT.
  - Address advances by 4, modulo 2^24 (0xFFFFFC wraps to 0x000000). words_issued increments.
- WAIT:
  - Capture when spi_rd_data_available=1 and the byte buffer is empty. Same cycle: latch spi_rd_data into the 4-byte buffer and pulse spi_rd_ack for one cycle.
  - Next state is ISSUE if words_issued < NUM_WORDS, else FLUSH.
  - While the buffer is non-empty, no ack is given and spi_rd_data is held by spi_master.
- Prefetch: the next address is issued while the previous word's bytes drain. At most one word is buffered locally.
- Byte output:
  - Buffer non-empty -> out_valid=1, out_data = current byte, MSB byte first.
  - A byte advances only on out_valid & out_ready.
  - out_data, out_last are stable while out_valid=1 and out_ready=0.
  - Buffer empties on acceptance of byte 3.
  - out_last=1 only on byte 3 of word NUM_WORDS.
- FLUSH:
  - On acceptance of the out_last byte: done=1 for one cycle, busy=0.
  - Then LOOP=1 -> reload address=START_ADDR, words_issued=0, go to ISSUE.
  - Otherwise go to IDLE.
- Counters:
  - startup counter is 32 bits.
  - words_issued is $clog2(NUM_WORDS+1) bits.
  - byte index is 2 bits.
- start while busy, or in FLUSH, is ignored. start in the same cycle as done (LOOP=0) is ignored; only IDLE samples start.
- Back-to-back bytes: with out_ready held high, one byte is accepted per cycle.
- Reset mid-burst: state and buffered data are discarded, outputs go to reset values, and the startup delay repeats. The next burst restarts at START_ADDR.

Test Plan:
- Nominal burst: STARTUP_CYCLES=16, NUM_WORDS=2, AUTO_START=1, out_ready=1. Flash model returns 0x00010203, then 0x04050607.
  - spi_addr_data=0x100000, then 0x100004.
  - Stream is 00,01,02,03,04,05,06,07, with out_last only on 07.
  - One done pulse; busy low afterwards.
- Startup timing: pulse start at cycles 2 and 10 after reset release, AUTO_START=0.
  - No spi_addr_en pulse.
  - start at cycle 20 -> first spi_addr_en within 2 cycles.
- Backpressure: out_ready=0 for 10 cycles after byte 01.
  - out_data holds 01 and out_valid stays 1.
  - spi_rd_ack for the second word stays low until byte 03 is accepted.
  - No byte is lost or duplicated.
- Address wrap: START_ADDR=24'hFFFFFC, NUM_WORDS=2.
  - Issued addresses are 0xFFFFFC, then 0x000000.
- Reset mid-burst: pull reset_n low after 3 bytes are accepted.
  - out_valid, spi_addr_en, busy are 0 asynchronously.
  - After release: the 16-cycle delay repeats and the first address is 0x100000.
- Loop mode: LOOP=1, NUM_WORDS=1.
  - After done, the next spi_addr_en carries 0x100000 without any start pulse.
  - start during busy has no effect on the address sequence.
